// File: rtl/bit_serializer_if.sv
// Handshake and serial-stream bundle for bit_serializer.
// The master side supplies words; the slave side is the serializer.
interface bit_serializer_if #(
  parameter int unsigned WIDTH = 8
);
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic             ser_data;
  logic             ser_valid;
  logic             frame_done;
  logic             busy;

  modport master (
    output in_data, in_valid,
    input  in_ready, ser_data, ser_valid, frame_done, busy
  );

  modport slave (
    input  in_data, in_valid,
    output in_ready, ser_data, ser_valid, frame_done, busy
  );
endinterface

// File: rtl/bit_serializer.sv
// Parallel-to-serial front end: one WIDTH-bit word in over valid/ready, one bit out per clk.
// Optional feature macro PARITY_EN appends an even-parity bit after each word.
module bit_serializer #(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  bit_serializer_if.slave  bus
);
  localparam int unsigned CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT
`ifdef PARITY_EN
    , PARITY
`endif
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic             ser_data_q, ser_data_d;
  logic             ser_valid_q, ser_valid_d;
  logic             frame_done_q, frame_done_d;
  logic             in_ready_c;
  logic             accept;
`ifdef PARITY_EN
  logic             parity_q, parity_d;
`endif

  // Bit that leaves the word first, and the word with that bit consumed
  function automatic logic first_bit(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? w[WIDTH-1] : w[0];
  endfunction

  function automatic logic [WIDTH-1:0] consume(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? (w << 1) : (w >> 1);
  endfunction

  always_comb begin
    in_ready_c = 1'b0;
    if (!rst) begin
      case (state_q)
        IDLE:    in_ready_c = 1'b1;
`ifdef PARITY_EN
        SHIFT:   in_ready_c = 1'b0;
        PARITY:  in_ready_c = 1'b1;
`else
        SHIFT:   in_ready_c = (cnt_q == LAST);
`endif
        default: in_ready_c = 1'b0;
      endcase
    end
  end

  assign accept = bus.in_valid & in_ready_c;

  // Next state and next registered outputs; an accept always reloads, whatever the state
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    sreg_d       = sreg_q;
    ser_data_d   = 1'b0;
    ser_valid_d  = 1'b0;
    frame_done_d = 1'b0;
`ifdef PARITY_EN
    parity_d     = parity_q;
`endif
    case (state_q)
      IDLE: ;
      SHIFT: begin
        if (cnt_q != LAST) begin
          cnt_d       = cnt_q + CNT_W'(1);
          sreg_d      = consume(sreg_q);
          ser_data_d  = first_bit(sreg_q);
          ser_valid_d = 1'b1;
`ifndef PARITY_EN
          frame_done_d = (cnt_d == LAST);
`endif
        end else begin
`ifdef PARITY_EN
          state_d      = PARITY;
          ser_data_d   = parity_q;
          ser_valid_d  = 1'b1;
          frame_done_d = 1'b1;
`else
          state_d = IDLE;
`endif
        end
      end
`ifdef PARITY_EN
      PARITY: state_d = IDLE;
`endif
      default: state_d = IDLE;
    endcase

    if (accept) begin
      state_d      = SHIFT;
      cnt_d        = '0;
      sreg_d       = consume(bus.in_data);
      ser_data_d   = first_bit(bus.in_data);
      ser_valid_d  = 1'b1;
      frame_done_d = 1'b0;
`ifdef PARITY_EN
      parity_d     = ^bus.in_data;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      sreg_q       <= '0;
      ser_data_q   <= 1'b0;
      ser_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
`ifdef PARITY_EN
      parity_q     <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      sreg_q       <= sreg_d;
      ser_data_q   <= ser_data_d;
      ser_valid_q  <= ser_valid_d;
      frame_done_q <= frame_done_d;
`ifdef PARITY_EN
      parity_q     <= parity_d;
`endif
    end
  end

  assign bus.in_ready   = in_ready_c;
  assign bus.ser_data   = ser_data_q;
  assign bus.ser_valid  = ser_valid_q;
  assign bus.frame_done = frame_done_q;
  assign bus.busy       = (state_q != IDLE);
endmodule

// File: tb/tb_bit_serializer.sv
// Scoreboard bench for bit_serializer: an MSB-first and an LSB-first instance share one stimulus stream.
// Each accepted word is expanded into its expected bit sequence; a negedge monitor pops and compares.
module tb_bit_serializer;
  localparam int unsigned W = 8;
`ifdef PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  typedef struct packed {
    logic d;
    logic fd;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] in_data = '0;
  logic         in_valid = 1'b0;

  int  tests = 0;
  int  fails = 0;
  bit  armed = 1'b0;
  bit  last_acc = 1'b0;
  bit  m_rdy, m_acc;
  exp_t q[2][$];

  always #5 clk = ~clk;

  bit_serializer_if #(.WIDTH(W)) bus_m ();
  bit_serializer_if #(.WIDTH(W)) bus_l ();

  assign bus_m.in_data  = in_data;
  assign bus_m.in_valid = in_valid;
  assign bus_l.in_data  = in_data;
  assign bus_l.in_valid = in_valid;

  bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (.clk(clk), .rst(rst), .bus(bus_m));
  bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (.clk(clk), .rst(rst), .bus(bus_l));

  task automatic chk(input string name, input int idx, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s dut%0d t=%0t got %b want %b", name, idx, $time, act, exp);
    end
  endtask

  // Reference frame: data bits in the chosen order, then the parity bit when enabled
  function automatic void push_word(input int idx, input logic [W-1:0] w, input bit msb);
    exp_t e;
    for (int k = 0; k < int'(W); k++) begin
      e.d  = msb ? w[int'(W) - 1 - k] : w[k];
      e.fd = (k == int'(W) - 1) && !PAR;
      q[idx].push_back(e);
    end
    if (PAR) begin
      e.d  = ^w;
      e.fd = 1'b1;
      q[idx].push_back(e);
    end
  endfunction

  task automatic check_one(input int idx, input logic sd, input logic sv, input logic fd,
                           input logic ir, input logic bz, input bit rdy);
    exp_t e;
    bit   ev;
    ev = (q[idx].size() > 0);
    chk("ser_valid", idx, sv, ev);
    chk("busy", idx, bz, ev);
    chk("in_ready", idx, ir, rdy);
    if (ev) begin
      e = q[idx].pop_front();
      chk("ser_data", idx, sd, e.d);
      chk("frame_done", idx, fd, e.fd);
    end else begin
      chk("ser_data_idle", idx, sd, 1'b0);
      chk("frame_done_idle", idx, fd, 1'b0);
    end
  endtask

  // Monitor: ready is predicted from pending bits (at most the one on the wire)
  always @(negedge clk) begin
    if (armed) begin
      m_rdy = !rst && (q[0].size() <= 1);
      check_one(0, bus_m.ser_data, bus_m.ser_valid, bus_m.frame_done, bus_m.in_ready, bus_m.busy, m_rdy);
      check_one(1, bus_l.ser_data, bus_l.ser_valid, bus_l.frame_done, bus_l.in_ready, bus_l.busy, m_rdy);
      m_acc = in_valid && m_rdy;
      if (rst) begin
        q[0].delete();
        q[1].delete();
      end else if (m_acc) begin
        push_word(0, in_data, 1'b1);
        push_word(1, in_data, 1'b0);
      end
      last_acc = m_acc;
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [W-1:0] w);
    bit got;
    got = 1'b0;
    in_data  = w;
    in_valid = 1'b1;
    for (int n = 0; n < 200 && !got; n++) begin
      @(posedge clk);
      #1;
      got = last_acc;
    end
    in_valid = 1'b0;
    if (!got) begin
      tests++;
      fails++;
      $display("FAIL send_timeout word %h not accepted", w);
    end
  endtask

  task automatic poke(input logic [W-1:0] w);
    in_data  = w;
    in_valid = 1'b1;
    step(1);
    in_valid = 1'b0;
  endtask

  task automatic reset_pulse();
    rst = 1'b1;
    step(1);
    rst = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout");
    $fatal(1, "bench did not finish");
  end

  initial begin
    // Reset held two cycles with a word offered; it must not be taken
    in_valid = 1'b1;
    in_data  = 8'hAA;
    @(posedge clk);
    armed = 1'b1;
    step(1);
    rst      = 1'b0;
    in_valid = 1'b0;
    step(2);

    send(8'hB5);
    step(12);
    send(8'hB5);
    send(8'h0F);
    step(20);

    // Offer during bit 3 is ignored, reset during bit 5 aborts the frame
    send(8'hB5);
    step(2);
    poke(8'hFF);
    step(1);
    reset_pulse();
    step(12);

    send(8'h03);
    step(12);

    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 19) == 0) reset_pulse();
      if ($urandom_range(0, 3) == 0) poke(W'($urandom));
      step(int'($urandom_range(0, 3)));
      send(W'($urandom));
    end
    step(20);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
